// File: rtl/pulse_train_driver_if.sv
// Control and observation bundle between the pulse train driver and its user.
// The bench (master) drives the request and the G feedback; the driver (slave) drives the rest.
interface pulse_train_driver_if;
  logic       go;
  logic [4:0] n;
  logic [1:0] gap;
  logic       G;
  logic       S;
  logic       X;
  logic       busy;
  logic       done;
  logic       pass;
  logic       timeout;
  logic [4:0] sent;

  modport master (
    output go, n, gap, G,
    input  S, X, busy, done, pass, timeout, sent
  );

  modport slave (
    input  go, n, gap, G,
    output S, X, busy, done, pass, timeout, sent
  );
endinterface

// File: rtl/pulse_train_driver.sv
// Drives a counting block with a start strobe and a train of count pulses, then checks
// whether the block's completion flag G showed up when it should have.
module pulse_train_driver (
  input logic              clk,
  input logic              reset,
  pulse_train_driver_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StPulse,
    StGap,
    StWait,
    StDone
  } state_e;

  state_e     state_q, state_d;
  logic [4:0] n_lat_q, n_lat_d;
  logic [1:0] gap_lat_q, gap_lat_d;
  logic [4:0] sent_q, sent_d;
  logic [1:0] gap_cnt_q, gap_cnt_d;
  logic [2:0] wait_cnt_q, wait_cnt_d;
  logic       g_seen_q, g_seen_d;
  logic       pass_q, pass_d;
  logic       timeout_q, timeout_d;

  logic       expected_g;
  logic       g_final;

  // The counting block is expected to flag completion once it has counted 15 pulses.
  assign expected_g = (n_lat_q >= 5'd15);
  // Include this cycle's G so a flag arriving in the deciding cycle is not lost.
  assign g_final    = g_seen_q | bus.G;

  always_comb begin
    state_d    = state_q;
    n_lat_d    = n_lat_q;
    gap_lat_d  = gap_lat_q;
    sent_d     = sent_q;
    gap_cnt_d  = gap_cnt_q;
    wait_cnt_d = wait_cnt_q;
    g_seen_d   = g_seen_q;
    pass_d     = pass_q;
    timeout_d  = timeout_q;

    unique case (state_q)
      StIdle: begin
        if (bus.go) begin
          n_lat_d   = bus.n;
          gap_lat_d = bus.gap;
          sent_d    = 5'd0;
          pass_d    = 1'b0;
          timeout_d = 1'b0;
          g_seen_d  = 1'b0;
          state_d   = StStart;
        end
      end

      StStart: begin
        g_seen_d = g_final;
        if (n_lat_q != 5'd0) begin
          state_d = StPulse;
        end else begin
          wait_cnt_d = 3'd0;
          state_d    = StWait;
        end
      end

      StPulse: begin
        g_seen_d = g_final;
        if (sent_q != n_lat_q) begin
          sent_d = sent_q + 5'd1;
        end
        if (sent_d == n_lat_q) begin
          wait_cnt_d = 3'd0;
          state_d    = StWait;
        end else if (gap_lat_q == 2'd0) begin
          state_d = StPulse;
        end else begin
          gap_cnt_d = gap_lat_q;
          state_d   = StGap;
        end
      end

      StGap: begin
        g_seen_d = g_final;
        if (gap_cnt_q == 2'd1) begin
          state_d = StPulse;
        end else begin
          gap_cnt_d = gap_cnt_q - 2'd1;
        end
      end

      StWait: begin
        g_seen_d = g_final;
        if (g_final || (wait_cnt_q == 3'd7)) begin
          pass_d    = (g_final == expected_g);
          timeout_d = expected_g & ~g_final;
          state_d   = StDone;
        end else begin
          wait_cnt_d = wait_cnt_q + 3'd1;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      n_lat_q    <= 5'd0;
      gap_lat_q  <= 2'd0;
      sent_q     <= 5'd0;
      gap_cnt_q  <= 2'd0;
      wait_cnt_q <= 3'd0;
      g_seen_q   <= 1'b0;
      pass_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_lat_q    <= n_lat_d;
      gap_lat_q  <= gap_lat_d;
      sent_q     <= sent_d;
      gap_cnt_q  <= gap_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      g_seen_q   <= g_seen_d;
      pass_q     <= pass_d;
      timeout_q  <= timeout_d;
    end
  end

  // Strobes depend on the state register alone, never on inputs.
  assign bus.S       = (state_q == StStart);
  assign bus.X       = (state_q == StPulse);
  assign bus.busy    = (state_q != StIdle);
  assign bus.done    = (state_q == StDone);
  assign bus.pass    = pass_q;
  assign bus.timeout = timeout_q;
  assign bus.sent    = sent_q;

endmodule

// File: tb/tb_pulse_train_driver.sv
// Scoreboard bench for pulse_train_driver: each run pushes its expected completion,
// a negedge monitor pops and checks it when done fires.
module tb_pulse_train_driver;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pulse_train_driver_if bus ();

  pulse_train_driver dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int         cyc;
    logic       pass;
    logic       timeout;
    logic [4:0] sent;
  } exp_t;

  exp_t sb[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Any done with nothing queued is an error (e.g. a run aborted by reset).
  always @(negedge clk) begin
    exp_t e;
    if (bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_done", 32'(bus.done), 32'd0);
      end else begin
        e = sb.pop_front();
        check_eq("done_cycle", cyc, e.cyc);
        check_eq("pass", 32'(bus.pass), 32'(e.pass));
        check_eq("timeout", 32'(bus.timeout), 32'(e.timeout));
        check_eq("sent", 32'(bus.sent), 32'(e.sent));
      end
    end
  end

  // g_off: run-relative cycle (1 = S cycle) in which G is high, 0 = never.
  task automatic run_case(input int n, input int gap, input int g_off, input bit hold_go);
    int   len, ws, w, done_off, p;
    bit   exp_g, g_seen;
    logic exp_x;
    exp_t e;
    len = (n == 0) ? 0 : n + (n - 1) * gap;
    ws  = 2 + len;
    if (g_off >= 1 && g_off < ws) begin
      w = 1;
      g_seen = 1'b1;
    end else if (g_off >= ws && g_off < ws + 8) begin
      w = g_off - ws + 1;
      g_seen = 1'b1;
    end else begin
      w = 8;
      g_seen = 1'b0;
    end
    done_off  = ws + w;
    exp_g     = (n >= 15);
    @(posedge clk);
    #1;
    bus.n     = 5'(n);
    bus.gap   = 2'(gap);
    bus.go    = 1'b1;
    e.cyc     = cyc + done_off;
    e.pass    = (g_seen == exp_g);
    e.timeout = exp_g && !g_seen;
    e.sent    = 5'(n);
    sb.push_back(e);
    for (int off = 1; off <= done_off + 1; off++) begin
      @(posedge clk);
      #1;
      if (off == 1) begin
        // Scramble the inputs to confirm they were latched.
        bus.n   = 5'($urandom_range(31));
        bus.gap = 2'($urandom_range(3));
      end
      if (!hold_go || off == done_off + 1) bus.go = 1'b0;
      bus.G = (off == g_off);
      @(negedge clk);
      p = off - 2;
      exp_x = (off >= 2 && off <= 1 + len) ? ((p % (gap + 1)) == 0) : 1'b0;
      check_eq($sformatf("S n=%0d off=%0d", n, off), 32'(bus.S), 32'(off == 1));
      check_eq($sformatf("X n=%0d g=%0d off=%0d", n, gap, off), 32'(bus.X), 32'(exp_x));
      check_eq($sformatf("busy n=%0d off=%0d", n, off), 32'(bus.busy), 32'(off <= done_off));
      if (off == 1) check_eq("sent_clear", 32'(bus.sent), 32'd0);
    end
    bus.G = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_S"}, 32'(bus.S), 32'd0);
    check_eq({tag, "_X"}, 32'(bus.X), 32'd0);
    check_eq({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check_eq({tag, "_done"}, 32'(bus.done), 32'd0);
    check_eq({tag, "_pass"}, 32'(bus.pass), 32'd0);
    check_eq({tag, "_timeout"}, 32'(bus.timeout), 32'd0);
    check_eq({tag, "_sent"}, 32'(bus.sent), 32'd0);
  endtask

  initial begin
    reset   = 1'b1;
    bus.go  = 1'b0;
    bus.n   = 5'd0;
    bus.gap = 2'd0;
    bus.G   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;

    run_case(3, 0, 0, 1'b0);    // basic timing, 8-cycle wait, pass
    run_case(2, 2, 0, 1'b0);    // X pattern 1,0,0,1
    run_case(15, 0, 18, 1'b0);  // G in 2nd WAIT cycle
    run_case(20, 0, 0, 1'b0);   // expected G never comes: timeout
    run_case(4, 0, 3, 1'b1);    // early G during PULSE; go held through DONE
    run_case(0, 1, 0, 1'b0);    // no pulses
    run_case(31, 3, 0, 1'b0);   // maximum count and gap
    run_case(16, 1, 1, 1'b0);   // G during START
    run_case(14, 0, 19, 1'b0);  // unexpected G just under threshold

    // Abort in the middle of GAP, with a go while busy.
    @(posedge clk);
    #1;
    bus.n   = 5'd5;
    bus.gap = 2'd3;
    bus.go  = 1'b1;
    @(posedge clk);
    #1;
    bus.go = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    bus.go = 1'b1;
    @(negedge clk);
    check_eq("gap_busy", 32'(bus.busy), 32'd1);
    check_eq("gap_x", 32'(bus.X), 32'd0);
    check_eq("gap_sent", 32'(bus.sent), 32'd1);
    @(posedge clk);
    #1;
    bus.go = 1'b0;
    reset  = 1'b1;
    @(negedge clk);
    check_eq("busy_go_ignored", 32'(bus.S), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("abort");
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check_eq("abort_idle", 32'(bus.busy), 32'd0);
    end

    run_case(3, 1, 0, 1'b0);    // clean run after reset

    repeat (3) @(posedge clk);
    check_eq("sb_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pulse_train_driver.md
PULSE_TRAIN_DRIVER -- requirements
Module: pulse_train_driver

Interface
REQ-001 The module SHALL have port clk, input, 1 bit: system clock, all state updates on its rising edge.
REQ-002 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 The module SHALL have port go, input, 1 bit: start request, sampled only in IDLE.
REQ-004 The module SHALL have port n, input, 5 bits: number of X pulses to send, 0..31, latched on accepted go.
REQ-005 The module SHALL have port gap, input, 2 bits: idle cycles between consecutive X pulses, 0..3, latched on accepted go.
REQ-006 The module SHALL have port G, input, 1 bit: completion flag returned by the counting block under test.
REQ-007 The module SHALL have port S, output, 1 bit: start/clear strobe to the counting block.
REQ-008 The module SHALL have port X, output, 1 bit: count pulse to the counting block.
REQ-009 The module SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-010 The module SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-011 The module SHALL have port pass, output, 1 bit: result of the last run, held until the next accepted go.
REQ-012 The module SHALL have port timeout, output, 1 bit: the last run expected G but never saw it, held until the next accepted go.
REQ-013 The module SHALL have port sent, output, 5 bits: number of X pulses emitted in the current or last run.

Function
REQ-014 The module SHALL implement the states IDLE, START, PULSE, GAP, WAIT and DONE.
REQ-015 S, X, busy and done SHALL be decoded from the state register only, with no combinational path from any input.
REQ-016 On go=1 in IDLE at edge k, the module SHALL latch n and gap, clear sent, pass, timeout and g_seen, and enter START.
REQ-017 Consequence of REQ-016: S SHALL be high for exactly one cycle, the cycle after edge k.
REQ-018 go SHALL be ignored in every state other than IDLE.
REQ-019 From START, the next state SHALL be PULSE if n_lat>0, otherwise WAIT.
REQ-020 In PULSE, X SHALL be 1 for that cycle and sent SHALL increment by 1.
REQ-021 After that increment, the next state SHALL be: WAIT if sent equals n_lat; else PULSE if gap_lat=0 (X stays high continuously); else GAP.
REQ-022 GAP SHALL hold X=0 for exactly gap_lat cycles, using a 2-bit down-counter, then return to PULSE.
REQ-023 g_seen SHALL be a sticky flag, set by G=1 in any state from START through WAIT inclusive.
REQ-024 expected_G SHALL equal (n_lat >= 15).
REQ-025 WAIT SHALL last at most 8 cycles, counted by a 3-bit counter cleared on entry.
REQ-026 In WAIT, the module SHALL leave to DONE on the first cycle in which (g_seen OR G) is true.
REQ-027 If REQ-026 does not trigger, the module SHALL leave to DONE at the end of the 8th WAIT cycle.
REQ-028 On entry to DONE, the module SHALL set pass = (g_seen_final == expected_G).
REQ-029 On entry to DONE, the module SHALL set timeout = expected_G AND NOT g_seen_final.
REQ-030 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-031 A go=1 present during the DONE cycle SHALL be ignored; go is first accepted in IDLE.
REQ-032 sent SHALL saturate at n_lat and never wrap.
REQ-033 n=0 SHALL produce no X pulse.
REQ-034 G arriving early (before the last pulse) SHALL be recorded and SHALL cause immediate exit from WAIT.

Reset
REQ-035 reset=1 at a rising edge SHALL force IDLE and clear S, X, busy, done, pass, timeout, sent, g_seen and all internal counters to 0.
REQ-036 reset SHALL take priority over go and over any in-progress run.
REQ-037 A run aborted by reset SHALL produce no done pulse.

Verification
REQ-038 Bench case: n=3, gap=0, go at edge k, G held 0 -> S=1 at cycle k+1; X=1 at cycles k+2..k+4; WAIT for 8 cycles; done=1 at cycle k+13 with pass=1, timeout=0, sent=3.
REQ-039 Bench case: n=2, gap=2 -> X pattern after S is 1,0,0,1; sent=2.
REQ-040 Bench case: n=15, gap=0, G pulsed 1 in the 2nd WAIT cycle -> done one cycle later, pass=1, timeout=0.
REQ-041 Bench case: n=20, G never asserted -> done after 8 WAIT cycles, pass=0, timeout=1, sent=20.
REQ-042 Bench case: n=4, G asserted during PULSE -> exit WAIT on its first cycle, pass=0, timeout=0.
REQ-043 Bench case: reset=1 in the middle of GAP, plus go pulsed while busy -> all outputs 0 next cycle, no done pulse, busy go ignored; a new go after reset deasserts starts a clean run.
